// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: instruction formats, opcodes and the 12-bit range helper
// shared by the encoder, the decode stage and the benches.
package instr_encoder_pkg;

   typedef enum logic [1:0] {
      FMT_LOAD   = 2'b00,
      FMT_STORE  = 2'b01,
      FMT_BRANCH = 2'b10,
      FMT_JUMP   = 2'b11
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;

   // True when the value is a pure sign extension of its low 12 bits.
   function automatic logic imm_fits12(input logic [31:0] imm);
      return (imm[31:11] == 21'h00_0000) || (imm[31:11] == 21'h1F_FFFF);
   endfunction

endpackage

// File: rtl/instr_encoder_imm_scatter.sv
// imm_scatter: purely combinational assembly of a 32-bit RISC-V word from
// format, register fields and the truncated 12-bit immediate.
module imm_scatter
   import instr_encoder_pkg::*;
(
   input  logic [1:0]  fmt_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [11:0] imm_i,
   output logic [31:0] instr_o
);

   // Place the immediate bits where the decode stage expects them for each format.
   always_comb begin
      instr_o = 32'h0000_0000;
      case (fmt_e'(fmt_i))
         FMT_LOAD, FMT_JUMP: instr_o = {imm_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_STORE:          instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         FMT_BRANCH:         instr_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                                        imm_i[3:0], imm_i[10], opcode_i};
         default:            instr_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready encoder producing RISC-V words from fields.
// Defining ENCODER_RANGE_CHECK_EN builds the 12-bit range checker and err_count.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         fmt,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic [4:0]         rd,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic [31:0]        imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        instr,
   output logic               range_err,
   output logic [COUNT_W-1:0] enc_count,
   output logic [COUNT_W-1:0] err_count
);

   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
   localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic               a_valid_q;
   logic [1:0]         a_fmt_q;
   logic [6:0]         a_opcode_q;
   logic [2:0]         a_funct3_q;
   logic [4:0]         a_rd_q;
   logic [4:0]         a_rs1_q;
   logic [4:0]         a_rs2_q;
   logic [11:0]        a_imm_q;
   logic               a_rerr_q;
   logic               b_valid_q;
   logic [31:0]        b_instr_q;
   logic               b_rerr_q;
   logic [COUNT_W-1:0] enc_count_q;
   logic               b_adv_s;
   logic               a_ready_s;
   logic               accept_s;
   logic               deliver_s;
   logic               rerr_s;
   logic [31:0]        instr_s;

   assign b_adv_s   = !b_valid_q || out_ready;
   assign a_ready_s = !a_valid_q || b_adv_s;
   assign in_ready  = !reset && a_ready_s;
   assign accept_s  = in_valid && in_ready;
   assign deliver_s = b_valid_q && out_ready;

`ifdef ENCODER_RANGE_CHECK_EN
   assign rerr_s = !imm_fits12(imm);
`else
   logic unused_imm_s;
   assign unused_imm_s = ^imm[31:12];
   assign rerr_s       = 1'b0;
`endif

   // Stage A: capture the input fields and the range verdict.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid_q  <= 1'b0;
         a_fmt_q    <= 2'b00;
         a_opcode_q <= 7'h00;
         a_funct3_q <= 3'h0;
         a_rd_q     <= 5'h00;
         a_rs1_q    <= 5'h00;
         a_rs2_q    <= 5'h00;
         a_imm_q    <= 12'h000;
         a_rerr_q   <= 1'b0;
      end else if (a_ready_s) begin
         a_valid_q <= accept_s;
         if (accept_s) begin
            a_fmt_q    <= fmt;
            a_opcode_q <= opcode;
            a_funct3_q <= funct3;
            a_rd_q     <= rd;
            a_rs1_q    <= rs1;
            a_rs2_q    <= rs2;
            a_imm_q    <= imm[11:0];
            a_rerr_q   <= rerr_s;
         end
      end
   end

   imm_scatter u_scatter (
      .fmt_i    (a_fmt_q),
      .opcode_i (a_opcode_q),
      .funct3_i (a_funct3_q),
      .rd_i     (a_rd_q),
      .rs1_i    (a_rs1_q),
      .rs2_i    (a_rs2_q),
      .imm_i    (a_imm_q),
      .instr_o  (instr_s)
   );

   // Stage B: hold the assembled word until the consumer takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         b_valid_q <= 1'b0;
         b_instr_q <= 32'h0000_0000;
         b_rerr_q  <= 1'b0;
      end else if (b_adv_s) begin
         b_valid_q <= a_valid_q;
         if (a_valid_q) begin
            b_instr_q <= instr_s;
            b_rerr_q  <= a_rerr_q;
         end
      end
   end

   // Saturating count of delivered instructions.
   always_ff @(posedge clk) begin
      if (reset) begin
         enc_count_q <= {COUNT_W{1'b0}};
      end else if (deliver_s && (enc_count_q != CNT_MAX)) begin
         enc_count_q <= enc_count_q + CNT_ONE;
      end
   end

`ifdef ENCODER_RANGE_CHECK_EN
   logic [COUNT_W-1:0] err_count_q;

   // Saturating count of delivered instructions flagged out of range.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count_q <= {COUNT_W{1'b0}};
      end else if (deliver_s && b_rerr_q && (err_count_q != CNT_MAX)) begin
         err_count_q <= err_count_q + CNT_ONE;
      end
   end

   assign err_count = err_count_q;
`else
   assign err_count = {COUNT_W{1'b0}};
`endif

   assign out_valid = b_valid_q;
   assign instr     = b_instr_q;
   assign range_err = b_rerr_q;
   assign enc_count = enc_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder; expected words come from
// an independent shift-and-or model and are checked in order at the output.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int CW = 8;
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    fmt = 2'b00;
   logic [6:0]    opcode = 7'h00;
   logic [2:0]    funct3 = 3'h0;
   logic [4:0]    rd = 5'h00;
   logic [4:0]    rs1 = 5'h00;
   logic [4:0]    rs2 = 5'h00;
   logic [31:0]   imm = 32'h0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   instr;
   logic          range_err;
   logic [CW-1:0] enc_count;
   logic [CW-1:0] err_count;

   int checks = 0;
   int failures = 0;
   int delivered = 0;
   int err_delivered = 0;

   typedef struct {
      logic [31:0] instr;
      logic        rerr;
   } exp_t;
   exp_t sb_q[$];

   instr_encoder #(.COUNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
      .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
      .range_err(range_err), .enc_count(enc_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] model_instr(input logic [1:0] f, input logic [6:0] op,
         input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1,
         input logic [4:0] s2, input logic [31:0] im);
      logic [31:0] w;
      logic [31:0] u;
      u = im & 32'h0000_0FFF;
      w = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
      case (f)
         FMT_STORE:  w = w | (32'(s2) << 20) | ((u >> 5) << 25) | ((u & 32'h1F) << 7);
         FMT_BRANCH: w = w | (32'(s2) << 20) | (((u >> 11) & 32'h1) << 31)
                           | (((u >> 4) & 32'h3F) << 25) | ((u & 32'hF) << 8)
                           | (((u >> 10) & 32'h1) << 7);
         default:    w = w | (u << 20) | (32'(d) << 7);
      endcase
      return w;
   endfunction

   function automatic logic model_rerr(input logic [31:0] im);
`ifdef ENCODER_RANGE_CHECK_EN
      return !(($signed(im) >= -32'sd2048) && ($signed(im) <= 32'sd2047));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] dec_b(input logic [31:0] w);
      logic [11:0] h;
      h = {w[31], w[7], w[30:25], w[11:8]};
      return {{20{h[11]}}, h};
   endfunction

   function automatic logic [CW-1:0] sat(input int n);
      return (n >= 255) ? CMAX : CW'(n);
   endfunction

   // Scoreboard: check counters, pop on delivery, push on acceptance.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         checks++;
         if (enc_count !== sat(delivered)) begin
            failures++;
            $display("FAIL enc_count got=%0d exp=%0d", enc_count, sat(delivered));
         end
         checks++;
         if (err_count !== sat(err_delivered)) begin
            failures++;
            $display("FAIL err_count got=%0d exp=%0d", err_count, sat(err_delivered));
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output got=%h exp=none", instr);
            end else begin
               e = sb_q.pop_front();
               if (instr !== e.instr || range_err !== e.rerr) begin
                  failures++;
                  $display("FAIL sb_word got=%h/%b exp=%h/%b", instr, range_err, e.instr, e.rerr);
               end
               delivered++;
               if (e.rerr) err_delivered++;
            end
         end
         if (in_valid && in_ready) begin
            e.instr = model_instr(fmt, opcode, funct3, rd, rs1, rs2, imm);
            e.rerr  = model_rerr(imm);
            sb_q.push_back(e);
         end
      end
   end

   // Drive one transaction; returns at posedge+1 after it was accepted, in_valid still high.
   task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
      int t = 0;
      bit acc = 1'b0;
      in_valid = 1'b1; fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         t++;
      end
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL send_timeout got=not_accepted exp=accepted");
      end
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (out_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || instr !== 32'h0 || range_err !== 1'b0
          || enc_count !== 8'd0 || err_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_state got=%b%b %h %b %0d %0d exp=00 0 0 0 0",
                  in_ready, out_valid, instr, range_err, enc_count, err_count);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL in_ready_after_reset got=%b exp=1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load();
      send(FMT_LOAD, OP_LOAD, 3'd2, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL load_latency_n1 got=%b exp=0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || instr !== 32'hFFC1_2283 || range_err !== 1'b0) begin
         failures++;
         $display("FAIL load_word got=%b/%h/%b exp=1/ffc12283/0", out_valid, instr, range_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      bit ok;
      send(FMT_STORE, OP_STORE, 3'd2, 5'd0, 5'd2, 5'd6, 32'd8);
      send(FMT_STORE, OP_STORE, 3'd2, 5'd31, 5'd2, 5'd6, 32'd8);
      in_valid = 1'b0;
      wait_out(ok);
      checks++;
      if (!ok || instr !== 32'h0061_2423) begin
         failures++;
         $display("FAIL store_word got=%h exp=00612423", instr);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || instr !== 32'h0061_2423) begin
         failures++;
         $display("FAIL store_rd_ignored got=%b/%h exp=1/00612423", out_valid, instr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_branch();
      bit ok;
      send(FMT_BRANCH, OP_BRANCH, 3'd1, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFE);
      in_valid = 1'b0;
      wait_out(ok);
      checks++;
      if (!ok || instr !== 32'hFE00_9EE3) begin
         failures++;
         $display("FAIL branch_word got=%h exp=fe009ee3", instr);
      end
      checks++;
      if (dec_b(instr) !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL branch_roundtrip got=%h exp=fffffffe", dec_b(instr));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_range();
      bit ok;
      logic exp_e;
      int e0;
      logic [11:0] hi;
      e0 = err_delivered;
`ifdef ENCODER_RANGE_CHECK_EN
      exp_e = 1'b1;
`else
      exp_e = 1'b0;
`endif
      send(FMT_LOAD, OP_LOAD, 3'd0, 5'd1, 5'd3, 5'd0, 32'h0000_0800);
      in_valid = 1'b0;
      wait_out(ok);
      hi = instr[31:20];
      checks++;
      if (!ok || hi !== 12'h800 || range_err !== exp_e) begin
         failures++;
         $display("FAIL range_word got=%h/%b exp=800/%b", hi, range_err, exp_e);
      end
      @(posedge clk); #1;
      checks++;
      if (err_count !== sat(e0 + int'(exp_e))) begin
         failures++;
         $display("FAIL range_err_count got=%0d exp=%0d", err_count, sat(e0 + int'(exp_e)));
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w0;
      int acc_n = 0;
      int d0;
      d0 = delivered;
      w0 = model_instr(FMT_LOAD, OP_LOAD, 3'd0, 5'd4, 5'd7, 5'd0, 32'd1);
      out_ready = 1'b0;
      in_valid = 1'b1; fmt = FMT_LOAD; opcode = OP_LOAD; funct3 = 3'd0; rd = 5'd4;
      rs1 = 5'd7; rs2 = 5'd0; imm = 32'd1;
      for (int c = 0; c < 4; c++) begin
         bit a;
         @(negedge clk);
         a = in_ready;
         if (c >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || instr !== w0) begin
               failures++;
               $display("FAIL bp_stable got=%b/%h exp=1/%h", out_valid, instr, w0);
            end
         end
         @(posedge clk); #1;
         if (a) begin
            acc_n++;
            imm = 32'(acc_n + 1);
         end
      end
      @(negedge clk);
      checks++;
      if (acc_n != 2 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_accepts got=%0d/%b exp=2/0", acc_n, in_ready);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(FMT_LOAD, OP_LOAD, 3'd0, 5'd4, 5'd7, 5'd0, 32'd3);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (enc_count !== sat(d0 + 3) || sb_q.size() != 0) begin
         failures++;
         $display("FAIL bp_drain got=%0d/%0d exp=%0d/0", enc_count, sb_q.size(), sat(d0 + 3));
      end
   endtask

   task automatic test_back_to_back();
      bit done = 1'b0;
      fork
         begin
            for (int i = 0; i < 270; i++) begin
               logic [1:0] f;
               logic [6:0] op;
               logic [31:0] im;
               int v;
               f = 2'($urandom_range(0, 3));
               case (f)
                  FMT_LOAD:   op = OP_LOAD;
                  FMT_STORE:  op = OP_STORE;
                  FMT_BRANCH: op = OP_BRANCH;
                  default:    op = OP_JALR;
               endcase
               v = int'($urandom_range(0, 4095)) - 2048;
               im = ($urandom_range(0, 1) == 1) ? $urandom() : 32'(v);
               send(f, op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), im);
            end
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (enc_count !== CMAX || sb_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_saturate got=%0d/%0d exp=%0d/0", enc_count, sb_q.size(), CMAX);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(FMT_JUMP, OP_JALR, 3'd0, 5'd1, 5'd2, 5'd0, 32'd16);
      send(FMT_LOAD, OP_LOAD, 3'd3, 5'd9, 5'd8, 5'd0, 32'd32);
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || enc_count !== 8'd0 || err_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_mid got=%b/%0d/%0d exp=0/0/0", out_valid, enc_count, err_count);
      end
      sb_q.delete();
      delivered = 0;
      err_delivered = 0;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_stale got=%b/%h exp=0", out_valid, instr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_branch();
      test_range();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the decode-stage immediate sign extension.
- Accepts instruction fields plus a 32-bit signed immediate for LOAD, STORE, BRANCH and JUMP (JALR-style I-type) formats. Scatters the immediate into RISC-V bit positions and emits the 32-bit instruction word.
- Two-stage valid/ready pipeline. Feeds the instruction-memory loader and self-check benches, so round-trip decode(encode(x)) == x.

Parameters:
- COUNT_W, 8, width of saturating encoded-instruction and range-error counters

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- fmt  in  2  format select: LOAD / STORE / BRANCH / JUMP
- opcode  in  7  placed verbatim in instr[6:0]
- funct3  in  3  placed in instr[14:12]
- rd  in  5  instr[11:7] (LOAD/JUMP only)
- rs1  in  5  instr[19:15]
- rs2  in  5  instr[24:20] (STORE/BRANCH only)
- imm  in  32  signed immediate; BRANCH value in halfword units, as the decode stage produces it
- out_valid  out  1  instr valid
- out_ready  in  1  consumer accepts instr
- instr  out  32  encoded instruction
- range_err  out  1  imm did not fit 12-bit signed; qualified by out_valid
- enc_count  out  COUNT_W  instructions delivered, saturating
- err_count  out  COUNT_W  delivered instructions with range_err, saturating

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: in_ready=0 during the reset cycle and 1 after; out_valid=0, instr=0, range_err=0, enc_count=0, err_count=0.
- Stage A captures the fields on in_valid && in_ready and computes range_err = ~(imm[31:11] all 0 or all 1).
- Stage B registers the assembled word and range_err and drives the outputs.
- Latency: accept at cycle N gives out_valid at cycle N+2 when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready.
  - out_valid, instr and range_err stay stable while out_valid && !out_ready.
  - Stage A advances when B is empty or B transfers this cycle.
  - in_ready = !A_valid || A advances, so in_ready depends combinationally on out_ready.
  - Capacity is 2 entries. Order is preserved and nothing is dropped or duplicated.
- Assembly, using i = imm[11:0]:
  - LOAD/JUMP: {i[11:0], rs1, funct3, rd, opcode}
  - STORE: {i[11:5], rs2, rs1, funct3, i[4:0], opcode}
  - BRANCH: {i[11], i[9:4], rs2, rs1, funct3, i[3:0], i[10], opcode}
- Unused fields (rd in S/B; rs2 in I) are ignored and must not affect instr.
- Out-of-range imm: the word is still produced from the truncated i; only range_err flags the error.
- Counters:
  - Increment on out_valid && out_ready.
  - err_count increments only when range_err is also set.
  - Both hold at all-ones and never wrap.
- Reset mid-operation: both stages are invalidated and in-flight entries are discarded. Counters clear.
- Simultaneous accept and deliver in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro: ENCODER_RANGE_CHECK_EN.
- Defined: range_err and err_count behave as described above.
- Undefined: no range comparator is built; range_err is tied 0, err_count is tied 0, and imm is silently truncated to 12 bits.
- instr and timing are identical in both builds.

Decomposition:
- Shared package holds:
  - FMT_LOAD=2'b00, FMT_STORE=2'b01, FMT_BRANCH=2'b10, FMT_JUMP=2'b11
  - Opcode constants OP_LOAD=7'h03, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_JALR=7'h67
  - The decode stage uses the same constants.
- One natural sub-module, imm_scatter: purely combinational fmt+fields to instr. Instantiated in stage B; reusable by the bench as a reference model.

Test Plan:
- LOAD, imm=0xFFFFFFFC, rs1=2, funct3=2, rd=5, opcode=0x03 -> instr=0xFFC12283, range_err=0, out_valid two cycles after accept.
- STORE, imm=8, rs2=6, rs1=2, funct3=2, opcode=0x23 -> instr=0x00612423; setting rd=31 leaves instr unchanged.
- BRANCH, imm=0xFFFFFFFE, rs1=1, rs2=0, funct3=1, opcode=0x63 -> instr=0xFE009EE3; feeding this word to the decode-stage sign extension returns 0xFFFFFFFE.
- LOAD, imm=0x800 -> range_err=1, instr[31:20]=0x800, err_count increments on delivery. Without ENCODER_RANGE_CHECK_EN -> range_err=0, err_count stays 0.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 with 3 distinct words -> exactly 2 accepted, then in_ready=0; after out_ready=1, all 3 words emerge in order and enc_count=3.
- Assert reset while both stages are full -> next cycle out_valid=0, counters=0; no stale word appears after reset is released.
